// File: rtl/xmtr_if.sv
// Host-side handshake bundle for the xmtr serial frame transmitter.
//   data_in  : byte offered by the host
//   load     : one-cycle write strobe
//   ready    : holding buffer empty, so a load will be accepted
//   overrun  : sticky flag, a load arrived while the buffer was full
//   busy     : frame or inter-frame gap in progress
// master = host side, slave = transmitter side.
interface xmtr_if;
  logic [7:0] data_in;
  logic       load;
  logic       ready;
  logic       overrun;
  logic       busy;

  modport master (
    output data_in,
    output load,
    input  ready,
    input  overrun,
    input  busy
  );

  modport slave (
    input  data_in,
    input  load,
    output ready,
    output overrun,
    output busy
  );
endinterface

// File: rtl/xmtr.sv
// Serial frame transmitter, peer of the 8-bit header-match receiver.
// A byte written by the host lands in a one-entry holding buffer. Each
// frame is sent MSB first, one bit per clock: the MATCH header byte and
// then the data byte, optionally followed by GAP idle bit times.
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous, active-low
//   host       : handshake bundle (data_in, load, ready, overrun, busy)
//   serial_out : registered serial line to the receiver
module xmtr #(
  parameter logic [7:0]  MATCH = 8'hA5,
  parameter int unsigned GAP   = 1
) (
  input  logic   clock,
  input  logic   reset,
  xmtr_if.slave  host,
  output logic   serial_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic       IDLE_BIT = ~MATCH[7];
  localparam logic [3:0] GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [3:0]  gap_cnt;
  logic [14:0] shift;
  logic [7:0]  buffer;
  logic        ready_q;
  logic        overrun_q;
  logic        start;

  assign host.ready   = ready_q;
  assign host.overrun = overrun_q;
  assign host.busy    = (state != S_IDLE);

  // A new frame starts whenever the line becomes free and the buffer is
  // full: from IDLE, straight after the last body bit when there is no
  // gap, or at the end of the gap.
  always_comb begin
    start = 1'b0;
    if (!ready_q) begin
      case (state)
        S_IDLE:  start = 1'b1;
        S_BODY:  start = (cnt == 3'd7) && (GAP == 0);
        S_GAP:   start = (gap_cnt == 4'd0);
        default: start = 1'b0;
      endcase
    end
  end

  // serial_out is registered with the bit for the state being entered, so
  // the first header bit appears in the first HEAD cycle. The shift register
  // holds the bits still to come after the one currently on the line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      gap_cnt    <= '0;
      shift      <= '0;
      buffer     <= '0;
      ready_q    <= 1'b1;
      overrun_q  <= 1'b0;
      serial_out <= IDLE_BIT;
    end else begin
      if (host.load) begin
        if (ready_q) begin
          buffer    <= host.data_in;
          ready_q   <= 1'b0;
          overrun_q <= 1'b0;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      // start implies ready_q==0, so it never collides with an accept above
      if (start) begin
        state      <= S_HEAD;
        cnt        <= '0;
        shift      <= {MATCH[6:0], buffer};
        serial_out <= MATCH[7];
        ready_q    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            serial_out <= IDLE_BIT;
          end
          S_HEAD: begin
            cnt        <= cnt + 3'd1;
            shift      <= {shift[13:0], 1'b0};
            serial_out <= shift[14];
            if (cnt == 3'd7) state <= S_BODY;
          end
          S_BODY: begin
            cnt <= cnt + 3'd1;
            if (cnt != 3'd7) begin
              shift      <= {shift[13:0], 1'b0};
              serial_out <= shift[14];
            end else begin
              serial_out <= IDLE_BIT;
              if (GAP > 0) begin
                state   <= S_GAP;
                gap_cnt <= GAP_LOAD;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_GAP: begin
            serial_out <= IDLE_BIT;
            if (gap_cnt == 4'd0) state <= S_IDLE;
            else gap_cnt <= gap_cnt - 4'd1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xmtr.sv
// Testbench for xmtr: two instances (GAP=0 and GAP=1) share one stimulus
// stream and are compared every cycle against a frame-level model, plus
// directed scenarios with literal expectations.
module tb_xmtr;
  localparam logic [7:0] MATCH    = 8'hA5;
  localparam logic       IDLE_BIT = ~MATCH[7];

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       load    = 1'b0;
  logic [7:0] data_in = '0;
  logic       so0;
  logic       so1;

  xmtr_if h0();
  xmtr_if h1();

  assign h0.load    = load;
  assign h0.data_in = data_in;
  assign h1.load    = load;
  assign h1.data_in = data_in;

  xmtr #(.MATCH(MATCH), .GAP(0)) dut0 (
    .clock(clock), .reset(reset), .host(h0), .serial_out(so0)
  );
  xmtr #(.MATCH(MATCH), .GAP(1)) dut1 (
    .clock(clock), .reset(reset), .host(h1), .serial_out(so1)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Frame-level model: a frame is 16+gap bit times; m_rem counts the bit
  // times still to show, including the current one. Index k has GAP=k.
  logic        m_ready [2];
  logic        m_over  [2];
  logic [7:0]  m_buf   [2];
  logic [15:0] m_frm   [2];
  int          m_rem   [2];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_ready[k] = 1'b1;
        m_over[k]  = 1'b0;
        m_buf[k]   = '0;
        m_frm[k]   = '0;
        m_rem[k]   = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic rdy_pre;
        rdy_pre = m_ready[k];
        if (m_rem[k] > 0) m_rem[k] = m_rem[k] - 1;
        if (m_rem[k] == 0 && !rdy_pre) begin
          m_frm[k]   = {MATCH, m_buf[k]};
          m_rem[k]   = 16 + k;
          m_ready[k] = 1'b1;
        end
        if (load) begin
          if (rdy_pre) begin
            m_buf[k]   = data_in;
            m_ready[k] = 1'b0;
            m_over[k]  = 1'b0;
          end else begin
            m_over[k] = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic exp_serial(input int k);
    int pos;
    if (m_rem[k] == 0) return IDLE_BIT;
    pos = 16 + k - m_rem[k];
    if (pos < 16) return m_frm[k][15 - pos];
    return IDLE_BIT;
  endfunction

  task automatic cmp(input int k, input logic r, input logic o, input logic b, input logic s);
    check($sformatf("dut%0d ready", k),   r, m_ready[k]);
    check($sformatf("dut%0d overrun", k), o, m_over[k]);
    check($sformatf("dut%0d busy", k),    b, (m_rem[k] > 0));
    check($sformatf("dut%0d serial", k),  s, exp_serial(k));
  endtask

  always @(negedge clock) begin
    cmp(0, h0.ready, h0.overrun, h0.busy, so0);
    cmp(1, h1.ready, h1.overrun, h1.busy, so1);
  end

  task automatic tick(input logic l, input logic [7:0] d);
    load    = l;
    data_in = d;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((h0.busy || h1.busy || !h0.ready || !h1.ready) && n < 200) begin
      tick(1'b0, 8'h00);
      n++;
    end
    check("wait idle", {h0.busy, h1.busy, h0.ready, h1.ready}, 4'b0011);
  endtask

  logic [15:0] cap0;
  logic [15:0] cap1;
  logic [31:0] cap32;

  initial begin
    // 1: reset state, held and released
    repeat (2) @(negedge clock);
    check("rst ready",   {h0.ready, h1.ready}, 2'b11);
    check("rst overrun", {h0.overrun, h1.overrun}, 2'b00);
    check("rst busy",    {h0.busy, h1.busy}, 2'b00);
    check("rst serial",  {so0, so1}, 2'b00);
    reset = 1'b1;
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    check("post-rst state", {h0.ready, h1.ready, h0.overrun, h1.overrun,
                             h0.busy, h1.busy, so0, so1}, 8'b1100_0000);

    // 2: single frame 3C
    tick(1'b1, 8'h3C);
    check("t2 ready c0", h1.ready, 1'b0);
    cap0 = '0;
    cap1 = '0;
    for (int c = 1; c <= 18; c++) begin
      tick(1'b0, 8'h00);
      if (c <= 16) begin
        cap0 = {cap0[14:0], so0};
        cap1 = {cap1[14:0], so1};
      end
      if (c == 1)  check("t2 busy c1", h1.busy, 1'b1);
      if (c == 2)  check("t2 ready c2", h1.ready, 1'b1);
      if (c == 17) check("t2 busy c17", {h1.busy, h0.busy, so1}, 3'b100);
      if (c == 18) check("t2 busy c18", {h1.busy, so1}, 2'b00);
    end
    check("t2 frame gap1", cap1, 16'hA53C);
    check("t2 frame gap0", cap0, 16'hA53C);

    // 3: back-to-back frames with GAP=0
    cap32 = '0;
    tick(1'b1, 8'h01);
    for (int c = 1; c <= 32; c++) begin
      if (c == 2) tick(1'b1, 8'hFF);
      else        tick(1'b0, 8'h00);
      cap32 = {cap32[30:0], so0};
    end
    check("t3 stream gap0", cap32, 32'hA501_A5FF);
    wait_idle();

    // 4: overrun drops the byte, next accepted load clears the flag
    tick(1'b1, 8'h11);
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h22);
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h33);
    check("t4 overrun set", {h0.overrun, h1.overrun}, 2'b11);
    begin
      int n = 0;
      while (!(h0.ready && h1.ready) && n < 100) begin
        tick(1'b0, 8'h00);
        n++;
      end
    end
    tick(1'b1, 8'h44);
    check("t4 overrun clr", {h0.overrun, h1.overrun, h0.ready, h1.ready}, 4'b0000);
    wait_idle();

    // 6: load on the edge where the GAP=1 buffer drains is rejected
    tick(1'b1, 8'h55);
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h66);
    repeat (15) tick(1'b0, 8'h00);
    tick(1'b1, 8'h77);
    check("t6 drain edge gap1", {h1.overrun, h1.ready}, 2'b11);
    check("t6 drain edge gap0", {h0.overrun, h0.ready}, 2'b00);
    wait_idle();

    // 5: reset mid-body, then a clean A5 frame
    tick(1'b1, 8'hA5);
    repeat (12) tick(1'b0, 8'h00);
    check("t5 pre-rst busy", {h0.busy, h1.busy}, 2'b11);
    #2 reset = 1'b0;
    #1;
    check("t5 rst serial", {so0, so1}, {IDLE_BIT, IDLE_BIT});
    check("t5 rst busy",   {h0.busy, h1.busy}, 2'b00);
    check("t5 rst ready",  {h0.ready, h1.ready}, 2'b11);
    @(negedge clock);
    reset = 1'b1;
    tick(1'b1, 8'hA5);
    cap0 = '0;
    cap1 = '0;
    for (int c = 1; c <= 16; c++) begin
      tick(1'b0, 8'h00);
      cap0 = {cap0[14:0], so0};
      cap1 = {cap1[14:0], so1};
    end
    check("t5 frame gap0", cap0, 16'hA5A5);
    check("t5 frame gap1", cap1, 16'hA5A5);
    wait_idle();

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      tick(($urandom_range(0, 3) == 0), 8'($urandom));
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
